// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared state encoding and width defaults for the DMA bus master.
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

  localparam int unsigned C_ADDR_W = 16;
  localparam int unsigned C_DATA_W = 32;
  localparam int unsigned C_CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_REL  = 3'd4
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : dma_addr_counter
// Purpose  : Loadable address up-counter with enable; wraps modulo 2^ADDR_W.
// Revision : 1.0 - initial release
// ============================================================================
module dma_addr_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_count
);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dma_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_master
// Purpose  : HLD/HLDA bus-master DMA; copies io1 buffer words into data memory.
// Revision : 1.0 - initial release
// ============================================================================
module dma_bus_master
  import dma_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_to_dma,
  input  logic [ADDR_W-1:0] DMA_Address,
  input  logic [CNT_W-1:0]  DMA_data,
  output logic              HLD,
  input  logic              HLDA,
  output logic [ADDR_W-1:0] io_address,
  output logic              io_read,
  input  logic [DATA_W-1:0] io_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_write,
  output logic              busy,
  output logic              done
);

  dma_state_e        r_state;
  dma_state_e        w_next;
  logic              r_hld;
  logic              w_hld_next;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_done;
  logic              w_load;
  logic              w_step;
  logic [ADDR_W-1:0] w_src_ptr;
  logic [ADDR_W-1:0] w_dst_ptr;

  assign w_load = (r_state == S_IDLE) && request_to_dma;
  // A word is committed only if the grant is still held in WR.
  assign w_step = (r_state == S_WR) && HLDA;

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_src_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val ('0),
    .i_en       (w_step),
    .o_count    (w_src_ptr)
  );

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_dst_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (DMA_Address),
    .i_en       (w_step),
    .o_count    (w_dst_ptr)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (request_to_dma && (DMA_data != '0)) w_next = S_REQ;
      S_REQ:  if (HLDA && r_hld) w_next = S_RD;
      S_RD:   w_next = HLDA ? S_WR : S_REQ;
      S_WR: begin
        if (!HLDA)                          w_next = S_REQ;
        else if (r_remaining == CNT_W'(1))  w_next = S_REL;
        else                                w_next = S_RD;
      end
      S_REL:  if (!HLDA) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // HLD only rises once the core has shown HLDA low, so a stale grant left
  // over from an interrupted transfer can never be mistaken for a new one.
  assign w_hld_next = ((w_next == S_REQ) || (w_next == S_RD) || (w_next == S_WR))
                      && (r_hld || !HLDA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hld       <= 1'b0;
      r_remaining <= '0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hld       <= w_hld_next;
      r_mem_write <= w_step;
      r_done      <= (w_load && (DMA_data == '0)) || ((r_state == S_REL) && !HLDA);
      if (w_step) begin
        r_mem_addr  <= w_dst_ptr;
        r_mem_wdata <= io_readdata;
      end
      if (w_load) begin
        r_remaining <= DMA_data;
      end else if (w_step) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign HLD           = r_hld;
  assign io_read       = (r_state == S_RD);
  assign io_address    = w_src_ptr;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_addr;
  assign mem_writedata = r_mem_wdata;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_bus_master
// Purpose  : Self-checking bench for dma_bus_master with a core/io/memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request_to_dma = 1'b0;
  logic [15:0] DMA_Address = '0;
  logic [15:0] DMA_data = '0;
  logic        HLD;
  logic        HLDA = 1'b0;
  logic [15:0] io_address;
  logic        io_read;
  logic [31:0] io_readdata;
  logic [15:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_write;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dma_bus_master dut (
    .clk           (clk),
    .rst           (rst),
    .request_to_dma(request_to_dma),
    .DMA_Address   (DMA_Address),
    .DMA_data      (DMA_data),
    .HLD           (HLD),
    .HLDA          (HLDA),
    .io_address    (io_address),
    .io_read       (io_read),
    .io_readdata   (io_readdata),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_write     (mem_write),
    .busy          (busy),
    .done          (done)
  );

  // io1 buffer: synchronous read, data valid the cycle after io_read
  logic [31:0] iobuf [0:63];
  always @(posedge clk) io_readdata <= io_read ? iobuf[io_address[5:0]] : 'x;

  // Core model: grants after grant_delay cycles of HLD, optionally revokes
  // the grant for drop_len cycles during the WR of source word drop_src.
  int grant_delay = 1;
  int drop_src = -1;
  int drop_len = 0;
  int gcnt = 0;
  int drop_left = 0;
  bit drop_pend = 1'b0;
  always @(posedge clk) begin
    #3;
    if (drop_pend) begin
      drop_pend = 1'b0;
      drop_left = drop_len;
    end
    if (drop_left > 0) begin
      HLDA = 1'b0;
      drop_left--;
      gcnt = grant_delay;
    end else if (!HLD) begin
      HLDA = 1'b0;
      gcnt = 0;
    end else if (!HLDA) begin
      gcnt++;
      if (gcnt >= grant_delay) HLDA = 1'b1;
    end
    if (io_read && drop_src >= 0 && io_address == 16'(drop_src)) begin
      drop_pend = 1'b1;
      drop_src = -1;
    end
  end

  // Monitor
  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int cyc = 0, done_cnt = 0, hld_falls = 0, hld_high = 0;
  int first_hlda = -1, first_rd = -1;
  logic prev_hld = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (mem_write) begin
      wq_addr.push_back(mem_address);
      wq_data.push_back(mem_writedata);
      wq_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (HLD) hld_high++;
    if (prev_hld && !HLD) hld_falls++;
    prev_hld = HLD;
    if (HLDA && first_hlda < 0) first_hlda = cyc;
    if (io_read && first_rd < 0) first_rd = cyc;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cnt = 0; hld_falls = 0; hld_high = 0;
    first_hlda = -1; first_rd = -1;
  endtask

  task automatic start_xfer(input logic [15:0] base, input logic [15:0] n);
    clear_mon();
    DMA_Address = base;
    DMA_data = n;
    request_to_dma = 1'b1;
    tick();
    request_to_dma = 1'b0;
    DMA_Address = 16'($urandom);
    DMA_data = 16'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 400) begin
      tick();
      k++;
    end
    check({tag, " done_seen"}, 64'(done_cnt > 0), 64'(1));
    if (done_cnt == 0) begin
      rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    end
  endtask

  // Reference: word i of the buffer lands at (base + i) mod 2^16, once each.
  task automatic verify(input string tag, input logic [15:0] base, input int n, input bit gap);
    logic [15:0] ea;
    tick(); tick();
    check({tag, " nwrites"}, 64'(wq_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      ea = base + 16'(i);
      check($sformatf("%s addr[%0d]", tag, i), 64'(wq_addr[i]), 64'(ea));
      check($sformatf("%s data[%0d]", tag, i), 64'(wq_data[i]), 64'(iobuf[i]));
      if (gap && i > 0)
        check($sformatf("%s gap[%0d]", tag, i), 64'(wq_cyc[i] - wq_cyc[i-1]), 64'(2));
    end
    check({tag, " done_count"}, 64'(done_cnt), 64'(1));
    check({tag, " busy_end"}, 64'(busy), 64'(0));
    check({tag, " hld_end"}, 64'(HLD), 64'(0));
    check({tag, " hld_falls"}, 64'(hld_falls), 64'(1));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) iobuf[i] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    logic [15:0] base;
    fill_random();

    // Reset state
    tick(); tick(); tick();
    check("rst HLD", 64'(HLD), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst mem_write", 64'(mem_write), 64'(0));
    check("rst io_read", 64'(io_read), 64'(0));
    check("rst io_address", 64'(io_address), 64'(0));
    check("rst mem_address", 64'(mem_address), 64'(0));
    check("rst mem_writedata", 64'(mem_writedata), 64'(0));
    rst = 1'b0;
    tick();

    // Basic transfer
    iobuf[0] = 32'hA0; iobuf[1] = 32'hA1; iobuf[2] = 32'hA2;
    grant_delay = 1;
    start_xfer(16'h0100, 16'd3);
    wait_done("basic");
    check("basic rd_after_grant", 64'(first_rd - first_hlda), 64'(1));
    verify("basic", 16'h0100, 3, 1'b1);

    // Zero count
    clear_mon();
    DMA_Address = 16'h1234;
    DMA_data = 16'd0;
    request_to_dma = 1'b1;
    tick();
    request_to_dma = 1'b0;
    check("zero done_pulse", 64'(done), 64'(1));
    check("zero busy", 64'(busy), 64'(0));
    check("zero HLD", 64'(HLD), 64'(0));
    tick();
    check("zero done_drop", 64'(done), 64'(0));
    tick(); tick(); tick();
    check("zero done_count", 64'(done_cnt), 64'(1));
    check("zero hld_never", 64'(hld_high), 64'(0));
    check("zero no_writes", 64'(wq_addr.size()), 64'(0));

    // Grant lost during WR of word 1
    fill_random();
    base = 16'($urandom);
    drop_src = 1; drop_len = 5;
    start_xfer(base, 16'd4);
    wait_done("drop");
    verify("drop", base, 4, 1'b0);

    // Wrap-around
    fill_random();
    start_xfer(16'hFFFE, 16'd3);
    wait_done("wrap");
    verify("wrap", 16'hFFFE, 3, 1'b1);

    // Request while busy is ignored
    fill_random();
    base = 16'($urandom);
    start_xfer(base, 16'd5);
    k = 0;
    while (wq_addr.size() == 0 && k < 100) begin tick(); k++; end
    DMA_Address = 16'h0BAD;
    DMA_data = 16'd2;
    request_to_dma = 1'b1;
    tick();
    request_to_dma = 1'b0;
    check("ignore busy", 64'(busy), 64'(1));
    wait_done("ignore");
    verify("ignore", base, 5, 1'b1);

    // Reset during RD of word 2 of 5
    fill_random();
    base = 16'($urandom);
    start_xfer(base, 16'd5);
    k = 0;
    while (!(io_read && io_address == 16'd2) && k < 100) begin tick(); k++; end
    check("rstmid reached_rd2", 64'(io_read && io_address == 16'd2), 64'(1));
    rst = 1'b1;
    tick();
    check("rstmid HLD", 64'(HLD), 64'(0));
    check("rstmid busy", 64'(busy), 64'(0));
    check("rstmid mem_write", 64'(mem_write), 64'(0));
    check("rstmid done", 64'(done), 64'(0));
    rst = 1'b0;
    tick(); tick(); tick();
    check("rstmid no_done", 64'(done_cnt), 64'(0));
    check("rstmid partial_writes", 64'(wq_addr.size()), 64'(2));
    fill_random();
    base = 16'($urandom);
    start_xfer(base, 16'd3);
    wait_done("post_rst");
    verify("post_rst", base, 3, 1'b1);

    // Slow grant
    fill_random();
    grant_delay = 20;
    base = 16'($urandom);
    start_xfer(base, 16'd2);
    wait_done("slow");
    check("slow rd_after_grant", 64'(first_rd - first_hlda), 64'(1));
    check("slow hld_held", 64'(hld_high >= 22), 64'(1));
    verify("slow", base, 2, 1'b1);

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      bit dropped;
      fill_random();
      n = int'($urandom_range(1, 8));
      base = 16'($urandom);
      grant_delay = int'($urandom_range(1, 4));
      dropped = ($urandom_range(0, 1) == 1);
      if (dropped) begin
        drop_src = int'($urandom_range(0, n - 1));
        drop_len = int'($urandom_range(1, 4));
      end
      start_xfer(base, 16'(n));
      wait_done($sformatf("rand%0d", t));
      verify($sformatf("rand%0d", t), base, n, !dropped);
      drop_src = -1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_bus_master.md
Name: dma_bus_master

Overview:
- Bus-master side of the processor's HLD/HLDA hold handshake: the DMA controller that borrows the data bus from the MIPS core.
- The core programs a transfer by presenting a base address (DMA_Address) and word count (DMA_data), then pulses request_to_dma.
- The block raises HLD and waits for HLDA. Once the bus is granted it copies the words one at a time from the io1 buffer into data memory, then releases the bus.

Parameters:
- ADDR_W, 16, width of DMA_Address and of the memory/io address counters.
- DATA_W, 32, data bus word width.
- CNT_W, 16, width of DMA_data, which is used as the word count.

Ports:
- clk  input  1  system clock, same net as the core clock.
- rst  input  1  synchronous, active-high reset.
- request_to_dma  input  1  start pulse from io1; sampled only in IDLE.
- DMA_Address  input  ADDR_W  destination base address in data memory.
- DMA_data  input  CNT_W  number of words to transfer.
- HLD  output  1  bus hold request to the core.
- HLDA  input  1  hold acknowledge from the core.
- io_address  output  ADDR_W  io1 buffer read address.
- io_read  output  1  io1 read strobe.
- io_readdata  input  DATA_W  io1 read data, valid the cycle after io_read.
- mem_address  output  ADDR_W  data memory write address.
- mem_writedata  output  DATA_W  data memory write data.
- mem_write  output  1  data memory write strobe, one cycle per word.
- busy  output  1  high from acceptance of a request until return to IDLE.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal counters 0.
- rst has priority in every state. A reset in the middle of a transfer drops HLD and mem_write in the following cycle, with no done pulse.
- States: IDLE, REQ, RD, WR, REL.
- IDLE:
  - On request_to_dma=1, latch DMA_Address into dst_ptr, set src_ptr=0 and remaining=DMA_data.
  - If DMA_data=0: stay in IDLE, busy stays 0, pulse done in the next cycle, never assert HLD.
  - Otherwise go to REQ with busy=1.
- REQ: HLD=1. Wait for HLDA=1, then go to RD. There is no timeout.
- RD: io_read=1 and io_address=src_ptr for exactly one cycle, then go to WR.
- WR:
  - Capture io_readdata into mem_writedata. Drive mem_write=1 and mem_address=dst_ptr for one cycle.
  - Then increment src_ptr and dst_ptr and decrement remaining.
  - If remaining was 1, go to REL; otherwise go to RD.
  - Throughput is 1 word per 2 cycles once the bus is granted.
- REL: HLD=0. Wait for HLDA=0, then go to IDLE, pulse done and clear busy in the same edge.
- HLDA dropping to 0 in RD or WR:
  - The current word is not committed: suppress mem_write in that cycle and leave the pointers unchanged.
  - Return to REQ with HLD held at 1, then resume at the same word once the bus is re-granted.
- Address arithmetic is modulo 2^ADDR_W: dst_ptr wraps from 0xFFFF to 0x0000 silently.
- request_to_dma asserted while busy is ignored; it is not queued.
- HLD is registered. io_read, mem_write and done are decoded from registered state, so all outputs are glitch-free.
- HLD never asserts unless the previous REL handshake has completed (HLDA seen low).

Decomposition:
- Shared package dma_pkg: state encoding (IDLE, REQ, RD, WR, REL) and the ADDR_W/DATA_W/CNT_W defaults.
- One natural sub-module, dma_addr_counter: loadable up-counter with enable and wrap, instantiated for src_ptr and dst_ptr. The remaining-count down-counter stays inline.

Test Plan:
- Basic transfer:
  - Stimulus: DMA_Address=0x0100, DMA_data=3, request pulse, HLDA returned 1 cycle after HLD; io buffer holds 0xA0, 0xA1, 0xA2.
  - Required: mem writes 0xA0→0x0100, 0xA1→0x0101, 0xA2→0x0102 on alternating cycles; HLD falls after the third write; done pulses once after HLDA falls.
- Zero count:
  - Stimulus: DMA_data=0 with a request pulse.
  - Required: HLD, mem_write and busy stay 0; done pulses exactly 1 cycle later.
- Grant lost mid-transfer:
  - Stimulus: 4-word transfer with HLDA forced low during the WR of word 1 for 5 cycles.
  - Required: no write in that cycle; HLD stays 1; after re-grant word 1 is written once, then words 2 and 3; exactly 4 mem_write pulses in total.
- Wrap-around:
  - Stimulus: DMA_Address=0xFFFE, DMA_data=3.
  - Required: writes land at 0xFFFE, 0xFFFF, 0x0000.
- Reset and ignored request:
  - Stimulus: rst asserted during the RD of word 2 of 5.
  - Required: next cycle HLD=0, busy=0, no done pulse; a new request after rst is released completes normally.
  - Stimulus: request_to_dma pulsed while busy.
  - Required: the pulse is ignored and the in-progress count is unchanged.
- Slow grant:
  - Stimulus: HLDA withheld for 20 cycles after HLD rises.
  - Required: HLD stays high throughout; io_read stays 0 until the first cycle after HLDA=1.
